operand_collector: RTL

OPERAND_COLLECTOR -- requirements
Module: operand_collector

---
 rtl/config_pkg.sv | 16 +
 rtl/opcoll_sat_cnt.sv | 33 +++
 rtl/operand_collector.sv | 127 ++++++++++++
 3 files changed

// File: rtl/config_pkg.sv
// Shared types for the operand collector: operand/opcode widths and the collector FSM states.
package config_pkg;

    localparam int unsigned DataWidth = 32;
    localparam int unsigned CodeWidth = 8;

    typedef logic [DataWidth-1:0] data_t;
    typedef logic [CodeWidth-1:0] code_t;

    typedef enum logic [1:0] {
        StCollect,
        StWaitOp,
        StPresent
    } state_t;

endpackage

// File: rtl/opcoll_sat_cnt.sv
// Saturating event counter for the operand collector; only built with OPERAND_COLLECTOR_PERF_CNT_EN,
// so the default build carries no stray top-level module.
`ifdef OPERAND_COLLECTOR_PERF_CNT_EN
module opcoll_sat_cnt #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic             inc_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule
`endif

// File: rtl/operand_collector.sv
// Gathers NUM_BEATS register-file read beats plus one opcode into an operand bundle.
// OPERAND_COLLECTOR_PERF_CNT_EN adds saturating bundle/stall counters.
module operand_collector
    import config_pkg::*;
#(
    parameter int unsigned NUM_BEATS = 4
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  rd_data_valid_i,
    input  data_t                 rd_data_i,
    output logic                  rd_data_ready_o,
    input  logic                  fifo_opcode_valid_i,
    input  code_t                 fifo_opcode_i,
    output logic                  fifo_opcode_ready_o,
    output logic                  op_valid_o,
    input  logic                  op_ready_i,
    output code_t                 op_code_o,
    output data_t [NUM_BEATS-1:0] op_data_o
`ifdef OPERAND_COLLECTOR_PERF_CNT_EN
    ,
    output logic [31:0]           bundle_cnt_o,
    output logic [31:0]           stall_cnt_o
`endif
);

    localparam int unsigned CntWidth = $clog2(NUM_BEATS) + 1;
    localparam logic [CntWidth-1:0] LastBeat = CntWidth'(NUM_BEATS - 1);

    state_t                state_q, state_d;
    logic [CntWidth-1:0]   beat_cnt_q, beat_cnt_d;
    logic                  op_seen_q, op_seen_d;
    code_t                 code_q, code_d;
    data_t [NUM_BEATS-1:0] data_q, data_d;
    logic                  beat_acc;
    logic                  opcode_acc;

    assign rd_data_ready_o     = (state_q == StCollect);
    assign fifo_opcode_ready_o = (state_q != StPresent) && !op_seen_q;
    assign op_valid_o          = (state_q == StPresent);

    assign beat_acc   = rd_data_valid_i & rd_data_ready_o;
    assign opcode_acc = fifo_opcode_valid_i & fifo_opcode_ready_o;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        op_seen_d  = op_seen_q;
        code_d     = code_q;
        data_d     = data_q;

        if (opcode_acc) begin
            code_d    = fifo_opcode_i;
            op_seen_d = 1'b1;
        end

        unique case (state_q)
            StCollect: begin
                if (beat_acc) begin
                    for (int i = 0; i < NUM_BEATS; i++) begin
                        if (beat_cnt_q == CntWidth'(i)) begin
                            data_d[i] = rd_data_i;
                        end
                    end
                    // Counter parks at NUM_BEATS after the last beat; it is never a write index there.
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == LastBeat) begin
                        state_d = (op_seen_q || opcode_acc) ? StPresent : StWaitOp;
                    end
                end
            end
            StWaitOp: begin
                if (opcode_acc) begin
                    state_d = StPresent;
                end
            end
            StPresent: begin
                if (op_ready_i) begin
                    state_d    = StCollect;
                    beat_cnt_d = '0;
                    op_seen_d  = 1'b0;
                end
            end
            default: state_d = StCollect;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q    <= StCollect;
            beat_cnt_q <= '0;
            op_seen_q  <= 1'b0;
            code_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            op_seen_q  <= op_seen_d;
            code_q     <= code_d;
            data_q     <= data_d;
        end
    end

    assign op_code_o = code_q;
    assign op_data_o = data_q;

`ifdef OPERAND_COLLECTOR_PERF_CNT_EN
    opcoll_sat_cnt #(
        .Width (32)
    ) u_bundle_cnt (
        .clk_i   (clk_i),
        .arst_i  (arst_i),
        .inc_i   (op_valid_o & op_ready_i),
        .count_o (bundle_cnt_o)
    );

    opcoll_sat_cnt #(
        .Width (32)
    ) u_stall_cnt (
        .clk_i   (clk_i),
        .arst_i  (arst_i),
        .inc_i   (op_valid_o & ~op_ready_i),
        .count_o (stall_cnt_o)
    );
`endif

endmodule
